// File: rtl/pipe_flow_ctrl_pkg.sv
// rtl/pipe_flow_ctrl_pkg.sv - shared state encoding, latch-control bundle and defaults for pipe_flow_ctrl
package pipe_ctrl_pkg;

    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IMEM_WAIT = 2'd1,
        ST_DMEM_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } flow_state_t;

    // One pipeline latch: enable captures new contents, flush loads a bubble.
    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    typedef struct packed {
        logic        pc_we;
        latch_ctrl_t if_id;
        latch_ctrl_t id_ex;
        latch_ctrl_t ex_mem;
        latch_ctrl_t mem_wb;
    } flow_ctrl_t;

    // Free-flowing pipeline: everything advances, nothing is squashed.
    localparam flow_ctrl_t CTRL_FLOW = '{
        pc_we:  1'b1,
        if_id:  '{en: 1'b1, flush: 1'b0},
        id_ex:  '{en: 1'b1, flush: 1'b0},
        ex_mem: '{en: 1'b1, flush: 1'b0},
        mem_wb: '{en: 1'b1, flush: 1'b0}
    };

    // Fully frozen pipeline used once halted.
    localparam flow_ctrl_t CTRL_FROZEN = '0;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// rtl/pipe_flow_ctrl_if.sv - event inputs and latch controls of pipe_flow_ctrl; perf counters under PIPE_FLOW_CTRL_PERF_EN
interface pipe_flow_ctrl_if
    import pipe_ctrl_pkg::*;
`ifdef PIPE_FLOW_CTRL_PERF_EN
    #(parameter int CNT_W = DEF_CNT_W)
`endif
    ;

    logic       load_use_in;
    logic       redirect_in;
    logic       halt_in;
    logic       imem_stall_in;
    logic       imem_done_in;
    logic       dmem_stall_in;
    logic       dmem_done_in;

    logic       pc_we;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic       halted;
    logic       err;
    logic [2:0] state_out;

`ifdef PIPE_FLOW_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
`endif

    // Pipeline side: raises events, consumes latch controls.
    modport master (
        output load_use_in, redirect_in, halt_in,
        output imem_stall_in, imem_done_in, dmem_stall_in, dmem_done_in,
        input  pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  halted, err, state_out
`ifdef PIPE_FLOW_CTRL_PERF_EN
        , input stall_cycles, flush_count
`endif
    );

    // Sequencer side.
    modport slave (
        input  load_use_in, redirect_in, halt_in,
        input  imem_stall_in, imem_done_in, dmem_stall_in, dmem_done_in,
        output pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output halted, err, state_out
`ifdef PIPE_FLOW_CTRL_PERF_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/pipe_flow_ctrl_mem_wait_timer.sv
// rtl/pipe_flow_ctrl_mem_wait_timer.sv - wait-cycle counter with clear and expiry compare, shared by both memory wait states
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Counter only ever holds 0..MEM_TIMEOUT-1: expiry forces an exit, which clears it.
    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Expiry fires on the MEM_TIMEOUT-th consecutive wait cycle.
    assign expired = en && (cnt == LAST);

    // Count wait cycles; clear wins so a leaving cycle restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - prioritised stall/flush sequencer for the 5-stage pipeline; optional counters under PIPE_FLOW_CTRL_PERF_EN
module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
`ifdef PIPE_FLOW_CTRL_PERF_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic            clk,
    input  logic            rst,
    pipe_flow_ctrl_if.slave bus
);

    flow_state_t state;
    flow_state_t next_state;
    flow_ctrl_t  ctl;

    logic in_wait;
    logic expired;
    logic tmr_clr;
    logic halt_now;
    logic redir_acc;
    logic pend_set;
    logic pend_clr;
    logic err_set;
    logic err_q;
    logic redir_pend;
    logic halted_w;

    assign in_wait = (state == ST_IMEM_WAIT) || (state == ST_DMEM_WAIT);
    assign tmr_clr = in_wait && (next_state != state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (in_wait),
        .expired (expired)
    );

    // State, sticky error and pending-redirect flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            err_q      <= 1'b0;
            redir_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (pend_clr) begin
                redir_pend <= 1'b0;
            end else if (pend_set) begin
                redir_pend <= 1'b1;
            end
        end
    end

    // Next state and latch controls, decided in the same cycle as the events.
    always_comb begin
        next_state = state;
        ctl        = CTRL_FLOW;
        halt_now   = 1'b0;
        redir_acc  = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        err_set    = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (bus.halt_in) begin
                    halt_now   = 1'b1;
                    ctl        = CTRL_FROZEN;
                    next_state = ST_HALTED;
                end else if (bus.dmem_stall_in) begin
                    ctl.pc_we        = 1'b0;
                    ctl.if_id.en     = 1'b0;
                    ctl.id_ex.en     = 1'b0;
                    ctl.ex_mem.en    = 1'b0;
                    ctl.mem_wb.flush = 1'b1;
                    next_state       = ST_DMEM_WAIT;
                end else if (bus.redirect_in) begin
                    // Target goes into PC; the three younger wrong-path slots are squashed.
                    redir_acc        = 1'b1;
                    ctl.if_id.flush  = 1'b1;
                    ctl.id_ex.flush  = 1'b1;
                    ctl.ex_mem.flush = 1'b1;
                end else if (bus.imem_stall_in) begin
                    ctl.pc_we       = 1'b0;
                    ctl.if_id.flush = 1'b1;
                    next_state      = ST_IMEM_WAIT;
                end else if (bus.load_use_in) begin
                    ctl.pc_we       = 1'b0;
                    ctl.if_id.en    = 1'b0;
                    ctl.id_ex.flush = 1'b1;
                end
            end

            ST_IMEM_WAIT: begin
                // Fetch starved: IF/ID gets bubbles while older work drains.
                ctl.pc_we       = 1'b0;
                ctl.if_id.flush = 1'b1;
                if (bus.redirect_in) begin
                    redir_acc        = 1'b1;
                    ctl.pc_we        = 1'b1;
                    ctl.id_ex.flush  = 1'b1;
                    ctl.ex_mem.flush = 1'b1;
                end
                if (bus.imem_done_in) begin
                    next_state = ST_RUN;
                    pend_clr   = 1'b1;
                    // Only a fetch with no redirect since it was issued is on the right path.
                    if (!bus.redirect_in && !redir_pend) begin
                        ctl.pc_we       = 1'b1;
                        ctl.if_id.flush = 1'b0;
                    end
                end else begin
                    pend_set = bus.redirect_in;
                    if (expired) begin
                        err_set    = 1'b1;
                        next_state = ST_HALTED;
                    end
                end
            end

            ST_DMEM_WAIT: begin
                // EX is frozen here, so redirect_in is not looked at.
                if (bus.halt_in) begin
                    halt_now   = 1'b1;
                    ctl        = CTRL_FROZEN;
                    next_state = ST_HALTED;
                end else if (bus.dmem_done_in) begin
                    next_state = ST_RUN;
                end else begin
                    ctl.pc_we        = 1'b0;
                    ctl.if_id.en     = 1'b0;
                    ctl.id_ex.en     = 1'b0;
                    ctl.ex_mem.en    = 1'b0;
                    ctl.mem_wb.flush = 1'b1;
                    if (expired) begin
                        err_set    = 1'b1;
                        next_state = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                ctl = CTRL_FROZEN;
            end

            default: begin
                ctl        = CTRL_FROZEN;
                next_state = ST_HALTED;
            end
        endcase
    end

    assign halted_w = (state == ST_HALTED) || halt_now;

    assign bus.pc_we        = ctl.pc_we;
    assign bus.if_id_en     = ctl.if_id.en;
    assign bus.id_ex_en     = ctl.id_ex.en;
    assign bus.ex_mem_en    = ctl.ex_mem.en;
    assign bus.mem_wb_en    = ctl.mem_wb.en;
    assign bus.if_id_flush  = ctl.if_id.flush;
    assign bus.id_ex_flush  = ctl.id_ex.flush;
    assign bus.ex_mem_flush = ctl.ex_mem.flush;
    assign bus.mem_wb_flush = ctl.mem_wb.flush;
    assign bus.halted       = halted_w;
    assign bus.err          = err_q;
    assign bus.state_out    = {1'b0, state};

`ifdef PIPE_FLOW_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Saturating counts of stalled (not halted) cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ctl.pc_we && !halted_w && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redir_acc && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;
`else
    logic unused_redir_acc;
    assign unused_redir_acc = redir_acc;
`endif

endmodule
